// File: rtl/alu_rr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// alu_rr_arbiter_pkg
//   Shared definitions for the round-robin ALU arbiter and its picker.
//   Contents:
//     NREQ           number of requesters sharing the ALU (4)
//     state_t        arbiter FSM encodings (IDLE/START/WAIT/RESP)
//     onehot_to_idx  one-hot grant vector -> 2-bit requester index
//     idx_to_onehot  2-bit requester index -> one-hot grant vector
// -----------------------------------------------------------------------------
package alu_rr_arbiter_pkg;

  localparam int NREQ = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Returns the index of the set bit. The grant vector is one-hot by
  // construction, so if several bits were ever set the highest one wins.
  function automatic logic [1:0] onehot_to_idx(input logic [NREQ-1:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < NREQ; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  function automatic logic [NREQ-1:0] idx_to_onehot(input logic [1:0] idx);
    return NREQ'(1) << idx;
  endfunction

endpackage

// File: rtl/alu_rr_arbiter_rr_pick4.sv
// -----------------------------------------------------------------------------
// rr_pick4
//   Combinational 4-way round-robin picker. Searches the request vector
//   starting just after the previous winner and wrapping around, so the
//   previous winner has the lowest priority.
//   Ports:
//     i_req  [3:0]  active requests
//     i_last [1:0]  index of the previous winner
//     o_any         at least one request is active
//     o_idx  [1:0]  index of the selected requester (0 when o_any is low)
// -----------------------------------------------------------------------------
module rr_pick4
  import alu_rr_arbiter_pkg::*;
(
  input  logic [NREQ-1:0] i_req,
  input  logic [1:0]      i_last,
  output logic            o_any,
  output logic [1:0]      o_idx
);

  logic [1:0] w_cand;

  // Walk the candidates from farthest (the previous winner itself, k=NREQ)
  // to nearest (last+1); the last hit written is the highest priority one.
  always_comb begin
    o_any  = |i_req;
    o_idx  = 2'd0;
    w_cand = 2'd0;
    for (int k = NREQ; k >= 1; k--) begin
      w_cand = i_last + 2'(k);
      if (i_req[w_cand]) o_idx = w_cand;
    end
  end

endmodule

// File: rtl/alu_rr_arbiter.sv
// -----------------------------------------------------------------------------
// alu_rr_arbiter
//   Round-robin arbiter sharing one 32-bit ALU among 4 requesters. It drives
//   the select lines of the operand/opcode mux bank, launches the ALU with a
//   one-cycle start pulse, waits for the ALU's done and returns a one-cycle
//   done pulse (with err when the ALU never answered) to the granted
//   requester.
//
//   Optional feature macro: ALU_ARB_LOCK_EN
//     defined   -> adds i_lock[3:0]; a requester holding lock and req in the
//                  response cycle keeps the round-robin pointer on itself and
//                  is granted again next (back-to-back dependent ops).
//     undefined -> no lock port; the pointer always advances.
//
//   Parameters:
//     TIMEOUT  cycles allowed in WAIT without i_alu_done (2..255)
//     TW       width of the timeout counter; must hold TIMEOUT
//
//   Ports:
//     i_clk        clock, all state changes on posedge
//     i_rst        synchronous active-high reset; aborts an op silently
//     i_req[3:0]   request per requester, held until its done pulse
//     i_alu_done   ALU result valid; only looked at in START and WAIT
//     i_lock[3:0]  (ALU_ARB_LOCK_EN only) keep grant on current winner
//     o_gnt[3:0]   one-hot grant, 0 when idle
//     o_sel1       mux select MSB = granted index[1]
//     o_sel0       mux select LSB = granted index[0]
//     o_alu_start  one-cycle ALU launch pulse
//     o_done[3:0]  one-hot one-cycle completion pulse
//     o_err        one-cycle pulse alongside o_done when the op timed out
//     o_dbg_state  current FSM state, for observation only
//
//   Handshake: a requester raises i_req and holds it until it sees its bit
//   of o_done; the arbiter raises o_alu_start for exactly one cycle and then
//   treats the first i_alu_done seen in START or WAIT as completion. The
//   completion pulse appears the cycle after RESP, together with gnt=0.
//   Timing (best case): req sampled at cycle 0 -> gnt/alu_start at 1 ->
//   done at 3, giving at most one op every 3 cycles.
// -----------------------------------------------------------------------------
module alu_rr_arbiter
  import alu_rr_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int TW      = 8
)(
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [NREQ-1:0] i_req,
  input  logic            i_alu_done,
`ifdef ALU_ARB_LOCK_EN
  input  logic [NREQ-1:0] i_lock,
`endif
  output logic [NREQ-1:0] o_gnt,
  output logic            o_sel1,
  output logic            o_sel0,
  output logic            o_alu_start,
  output logic [NREQ-1:0] o_done,
  output logic            o_err,
  output state_t          o_dbg_state
);

  localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT - 1);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t          r_state;
  logic [NREQ-1:0] r_gnt;
  logic [1:0]      r_sel;
  logic            r_start;
  logic [NREQ-1:0] r_done;
  logic            r_err;
  logic [TW-1:0]   r_tcnt;
  logic [1:0]      r_last;
  logic            r_timed_out;

  // ---------------------------------------------------------------------------
  // Combinational signals
  // ---------------------------------------------------------------------------
  state_t          w_state_nxt;
  logic [NREQ-1:0] w_gnt_nxt;
  logic [1:0]      w_sel_nxt;
  logic            w_start_nxt;
  logic [NREQ-1:0] w_done_nxt;
  logic            w_err_nxt;
  logic [TW-1:0]   w_tcnt_nxt;
  logic [1:0]      w_last_nxt;
  logic            w_timed_out_nxt;

  logic            w_any;
  logic [1:0]      w_pick_idx;
  logic [1:0]      w_cur_idx;
  logic            w_tcnt_exp;
  logic            w_hold_ptr;

  rr_pick4 u_pick (
    .i_req  (i_req),
    .i_last (r_last),
    .o_any  (w_any),
    .o_idx  (w_pick_idx)
  );

  assign w_cur_idx  = onehot_to_idx(r_gnt);
  assign w_tcnt_exp = (r_tcnt == TCNT_LAST);

`ifdef ALU_ARB_LOCK_EN
  // A locked, still-requesting winner keeps the pointer where it was, so the
  // picker lands on the same requester again in IDLE.
  assign w_hold_ptr = i_lock[w_cur_idx] & i_req[w_cur_idx];
`else
  assign w_hold_ptr = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM process 1: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM process 2: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_any) w_state_nxt = ST_START;
      ST_START: w_state_nxt = i_alu_done ? ST_RESP : ST_WAIT;
      // alu_done wins over expiry when both happen in the same cycle.
      ST_WAIT:  if (i_alu_done || w_tcnt_exp) w_state_nxt = ST_RESP;
      ST_RESP:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM process 3: output / datapath next values
  // All outputs are registered, so this block computes what they become on
  // the edge that leaves the current state.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_gnt_nxt       = r_gnt;
    w_sel_nxt       = r_sel;      // select lines hold through IDLE
    w_start_nxt     = 1'b0;
    w_done_nxt      = '0;
    w_err_nxt       = 1'b0;
    w_tcnt_nxt      = r_tcnt;
    w_last_nxt      = r_last;
    w_timed_out_nxt = r_timed_out;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_gnt_nxt       = idx_to_onehot(w_pick_idx);
          w_sel_nxt       = w_pick_idx;
          w_start_nxt     = 1'b1;
          w_timed_out_nxt = 1'b0;
        end
      end
      ST_START: begin
        w_tcnt_nxt = '0;
      end
      ST_WAIT: begin
        if (!i_alu_done) begin
          if (w_tcnt_exp) begin
            w_timed_out_nxt = 1'b1;
          end else begin
            w_tcnt_nxt = r_tcnt + TW'(1);
          end
        end
      end
      ST_RESP: begin
        w_done_nxt = r_gnt;
        w_err_nxt  = r_timed_out;
        w_gnt_nxt  = '0;
        if (!w_hold_ptr) w_last_nxt = w_cur_idx;
      end
      default: begin
        w_gnt_nxt = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output and datapath registers. Reset leaves the pointer on requester 3 so
  // requester 0 is the first winner.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_gnt       <= '0;
      r_sel       <= 2'd0;
      r_start     <= 1'b0;
      r_done      <= '0;
      r_err       <= 1'b0;
      r_tcnt      <= '0;
      r_last      <= 2'd3;
      r_timed_out <= 1'b0;
    end else begin
      r_gnt       <= w_gnt_nxt;
      r_sel       <= w_sel_nxt;
      r_start     <= w_start_nxt;
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
      r_tcnt      <= w_tcnt_nxt;
      r_last      <= w_last_nxt;
      r_timed_out <= w_timed_out_nxt;
    end
  end

  assign o_gnt       = r_gnt;
  assign o_sel1      = r_sel[1];
  assign o_sel0      = r_sel[0];
  assign o_alu_start = r_start;
  assign o_done      = r_done;
  assign o_err       = r_err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_rr_arbiter
//   Directed bench for alu_rr_arbiter: reset state, round-robin order under
//   full load, delayed ALU completion, timeout, completion on the expiry
//   cycle, request withdrawal after grant, reset during an op and (with
//   ALU_ARB_LOCK_EN) grant locking. Expected completions go into a queue
//   when a request is driven and are popped when o_done fires.
// -----------------------------------------------------------------------------
module tb_alu_rr_arbiter;
  import alu_rr_arbiter_pkg::*;

  localparam int TIMEOUT = 16;
  localparam int TW      = 8;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       alu_done;
`ifdef ALU_ARB_LOCK_EN
  logic [3:0] lock;
`endif
  logic [3:0] gnt;
  logic       sel1;
  logic       sel0;
  logic       alu_start;
  logic [3:0] done;
  logic       err;
  state_t     dbg_state;

  always #5 clk = ~clk;

  alu_rr_arbiter #(.TIMEOUT(TIMEOUT), .TW(TW)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req       (req),
    .i_alu_done  (alu_done),
`ifdef ALU_ARB_LOCK_EN
    .i_lock      (lock),
`endif
    .o_gnt       (gnt),
    .o_sel1      (sel1),
    .o_sel0      (sel0),
    .o_alu_start (alu_start),
    .o_done      (done),
    .o_err       (err),
    .o_dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int         n_checks = 0;
  int         n_errors = 0;
  logic [4:0] exp_q[$];      // {err, done one-hot}
  logic [4:0] sb_item;
  logic [1:0] m_last;        // bench's own round-robin pointer

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference picker: first requester after the previous winner, wrapping.
  function automatic logic [1:0] model_pick(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] idx;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (r[idx]) return idx;
    end
    return 2'd0;
  endfunction

  // Completion monitor: every done/err pulse must match the oldest entry.
  always @(posedge clk) begin
    #2;
    if (done !== 4'b0 || err !== 1'b0) begin
      n_checks++;
      assert (exp_q.size() > 0) else begin
        n_errors++;
        $error("FAIL sb_unexpected: observed done=%b err=%b expected no pulse", done, err);
      end
      if (exp_q.size() > 0) begin
        sb_item = exp_q.pop_front();
        chk("sb_done_err", 32'({err, done}), 32'(sb_item));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver: one complete ALU op. dly = cycles after alu_start at which
  // alu_done is raised (0 = in START, <0 = never). Called with the bench in
  // IDLE (or on the done cycle of the previous op), 1 ns after an edge.
  // ---------------------------------------------------------------------------
  task automatic run_op(input logic [3:0] req_val, input int dly, input bit drop_early,
                        input bit keep_req, input logic [3:0] lock_val);
    logic [1:0] w;
    logic [3:0] oh;
    logic       exp_err;
    int         e;
    w  = model_pick(req_val, m_last);
    oh = 4'b0001 << w;
    if (dly < 0 || dly > TIMEOUT) begin
      exp_err = 1'b1;
      e       = TIMEOUT + 2;
    end else begin
      exp_err = 1'b0;
      e       = dly + 2;
    end
    exp_q.push_back({exp_err, oh});
    req = req_val;
`ifdef ALU_ARB_LOCK_EN
    lock = lock_val;
`endif
    tick();
    chk("alu_start", 32'(alu_start), 32'(1));
    chk("gnt", 32'(gnt), 32'(oh));
    chk("sel", 32'({sel1, sel0}), 32'(w));
    if (drop_early) req = 4'b0;
    for (int c = 0; c < e; c++) begin
      alu_done = (c == dly);
      if (c == 1) begin
        chk("state_after_start", 32'(dbg_state), 32'((dly == 0) ? ST_RESP : ST_WAIT));
        chk("start_one_cycle", 32'(alu_start), 32'(0));
      end
      if (c > 0) begin
        chk("gnt_held", 32'(gnt), 32'(oh));
        chk("sel_held", 32'({sel1, sel0}), 32'(w));
        chk("no_early_done", 32'({err, done}), 32'(0));
      end
      tick();
    end
    alu_done = 1'b0;
    chk("done", 32'(done), 32'(oh));
    chk("err", 32'(err), 32'(exp_err));
    chk("gnt_clear", 32'(gnt), 32'(0));
    chk("sel_keep", 32'({sel1, sel0}), 32'(w));
    if (!(lock_val[w] && !drop_early && req_val[w])) m_last = w;
    if (!keep_req) req = 4'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst      = 1'b1;
    req      = 4'hF;
    alu_done = 1'b0;
`ifdef ALU_ARB_LOCK_EN
    lock     = 4'b0;
`endif
    m_last   = 2'd3;

    // Reset held two cycles with all requests active.
    tick();
    tick();
    chk("rst_gnt", 32'(gnt), 32'(0));
    chk("rst_sel", 32'({sel1, sel0}), 32'(0));
    chk("rst_start", 32'(alu_start), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_err", 32'(err), 32'(0));
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0;

    // Full load, immediate completion: grants 1,2,4,8,1 three cycles apart.
    for (int i = 0; i < 5; i++) begin
      run_op(4'hF, 0, 1'b0, (i < 4), 4'b0);
    end

    // Single requester 2, ALU answers 5 cycles after start.
    run_op(4'b0100, 5, 1'b0, 1'b0, 4'b0);

    // Requester 1, ALU never answers: timeout with err.
    run_op(4'b0010, -1, 1'b0, 1'b0, 4'b0);
    tick();
    chk("idle_after_timeout", 32'(dbg_state), 32'(ST_IDLE));
    chk("gnt_after_timeout", 32'(gnt), 32'(0));

    // alu_done on the very cycle the timeout expires: success, err=0.
    run_op(4'b1000, TIMEOUT, 1'b0, 1'b0, 4'b0);

    // Request withdrawn right after grant: op still completes.
    run_op(4'b0001, 0, 1'b1, 1'b0, 4'b0);

    // Contested request with a random ALU latency.
    run_op(4'b0110, int'($urandom_range(1, TIMEOUT - 1)), 1'b0, 1'b0, 4'b0);

    // Reset while in WAIT: silent abort, pointer back to 3.
    req = 4'b0100;
    tick();
    chk("abort_start", 32'(alu_start), 32'(1));
    tick();
    chk("abort_in_wait", 32'(dbg_state), 32'(ST_WAIT));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b0;
    m_last = 2'd3;
    chk("abort_gnt", 32'(gnt), 32'(0));
    chk("abort_done_err", 32'({err, done}), 32'(0));
    chk("abort_state", 32'(dbg_state), 32'(ST_IDLE));
    tick();
    chk("abort_quiet", 32'({err, done}), 32'(0));
    // Pointer at 3 picks requester 0 over 3.
    run_op(4'b1001, 0, 1'b0, 1'b0, 4'b0);

`ifdef ALU_ARB_LOCK_EN
    // Lock keeps requester 0 for three grants, then the pointer moves on.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_last = 2'd3;
    run_op(4'hF, 0, 1'b0, 1'b1, 4'b0001);
    run_op(4'hF, 0, 1'b0, 1'b1, 4'b0001);
    run_op(4'hF, 0, 1'b0, 1'b1, 4'b0000);
    run_op(4'hF, 0, 1'b0, 1'b0, 4'b0000);
`endif

    tick();
    tick();
    chk("sb_empty", 32'(exp_q.size()), 32'(0));
    chk("final_idle", 32'(dbg_state), 32'(ST_IDLE));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
